// File: rtl/fp_recode_pkg.sv
// Shared constants and types for the IEEE-754 to recoded-format load path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fp_recode_pkg;

  // Load format selector carried alongside the data
  typedef enum logic {
    FMT_S = 1'b0,
    FMT_D = 1'b1
  } fmt_e;

  // Exponent width / significand width (hidden bit included) per format
  localparam int E_S = 8;
  localparam int S_S = 24;
  localparam int E_D = 11;
  localparam int S_D = 53;

  // Recoded exponent bias: 2^(E-1) + 1
  localparam int BIAS_S = 129;
  localparam int BIAS_D = 1025;

  // Recoded widths: one sign bit, E+1 exponent bits, S-1 fraction bits
  localparam int REC_W_S = 33;
  localparam int REC_W_D = 65;

  localparam int RAW_W = 64;

  // Stage-2 payload, excluding the tag whose width is a top-level parameter
  typedef struct packed {
    logic [REC_W_D-1:0] dat;
    fmt_e               fmt;
    logic               snan;
    logic               sub;
  } rec_t;

endpackage

// File: rtl/fp_recode_unit.sv
// Combinational IEEE-754 to recoded conversion for one format (E exponent bits, S significand bits).
// Latency: 0 cycles, purely combinational.
// Backpressure: none, no state.
module fp_recode_unit #(
  parameter int E    = 8,
  parameter int S    = 24,
  parameter int BIAS = (1 << (E - 1)) + 1
) (
  input  logic [E+S-1:0] raw_i,
  output logic [E+S:0]   rec_o,
  output logic           snan_o,
  output logic           subnorm_o
);

  localparam int F   = S - 1;
  localparam int LZW = $clog2(F + 1);
  localparam logic [E:0] BIAS_V   = (E+1)'(BIAS);
  localparam logic [E:0] QNAN_BIT = (E+1)'(1) << (E - 2);

  logic         sign;
  logic [E-1:0] exp_in;
  logic [F-1:0] frac_in;
  logic         exp_zero;
  logic         exp_ones;
  logic         frac_zero;
  logic [LZW-1:0] lz;
  logic [F-1:0] frac_norm;
  logic [E:0]   exp_norm;
  logic [E:0]   exp_sub;
  logic [E:0]   exp_out;
  logic [F-1:0] frac_out;

  assign {sign, exp_in, frac_in} = raw_i;

  assign exp_zero  = ~|exp_in;
  assign exp_ones  = &exp_in;
  assign frac_zero = ~|frac_in;

  // Leading-zero count of the fraction: higher set bits overwrite lower ones, so the MSB-most one wins
  always_comb begin
    lz = LZW'(F);
    for (int i = 0; i < F; i++) begin
      if (frac_in[i]) lz = LZW'(F - 1 - i);
    end
  end

  // Subnormals shift the leading one out into the implicit position
  assign frac_norm = frac_in << (lz + LZW'(1));
  assign exp_sub   = BIAS_V - (E+1)'(lz);
  assign exp_norm  = {1'b0, exp_in} + BIAS_V;

  // Class-dependent exponent/fraction select; Inf falls out of the normal add (top bits 11)
  always_comb begin
    exp_out  = exp_norm;
    frac_out = frac_in;
    if (exp_zero) begin
      if (frac_zero) begin
        exp_out = '0;
      end else begin
        exp_out  = exp_sub;
        frac_out = frac_norm;
      end
    end else if (exp_ones && !frac_zero) begin
      exp_out = exp_norm | QNAN_BIT;
    end
  end

  assign rec_o     = {sign, exp_out, frac_out};
  assign snan_o    = exp_ones & ~frac_zero & ~frac_in[F-1];
  assign subnorm_o = exp_zero & ~frac_zero;

endmodule

// File: rtl/fp_load_recode_pipe.sv
// Two-stage load-data recoder (single/double -> recoded) feeding the FP regfile write port.
// Latency: 2 cycles acceptance to out_valid, 1 result per cycle.
// Backpressure: out_ready stalls S2 then S1; in_ready is combinational from out_ready and flush.
module fp_load_recode_pipe
  import fp_recode_pkg::*;
#(
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RAW_W-1:0]   in_data,
  input  logic               in_fmt,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [REC_W_D-1:0] out_data,
  output logic               out_fmt,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_snan,
  output logic [CNT_W-1:0]   subnorm_cnt,
  output logic [1:0]         occupancy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic               s1_v_q, s1_v_d;
  logic [RAW_W-1:0]   s1_raw_q;
  fmt_e               s1_fmt_q;
  logic [TAG_W-1:0]   s1_tag_q;

  logic               s2_v_q, s2_v_d;
  rec_t               s2_q;
  logic [TAG_W-1:0]   s2_tag_q;

  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               s2_adv;
  logic               in_acc;
  logic [REC_W_S-1:0] rec_sgl;
  logic [REC_W_D-1:0] rec_dbl;
  logic               snan_sgl, snan_dbl;
  logic               sub_sgl, sub_dbl;
  rec_t               rec_nxt;

  fp_recode_unit #(
    .E    (E_S),
    .S    (S_S),
    .BIAS (BIAS_S)
  ) u_rec_sgl (
    .raw_i     (s1_raw_q[E_S+S_S-1:0]),
    .rec_o     (rec_sgl),
    .snan_o    (snan_sgl),
    .subnorm_o (sub_sgl)
  );

  fp_recode_unit #(
    .E    (E_D),
    .S    (S_D),
    .BIAS (BIAS_D)
  ) u_rec_dbl (
    .raw_i     (s1_raw_q),
    .rec_o     (rec_dbl),
    .snan_o    (snan_dbl),
    .subnorm_o (sub_dbl)
  );

  // Pick the converter matching the S1 format; single results are zero-extended
  always_comb begin
    rec_nxt.fmt = s1_fmt_q;
    if (s1_fmt_q == FMT_D) begin
      rec_nxt.dat  = rec_dbl;
      rec_nxt.snan = snan_dbl;
      rec_nxt.sub  = sub_dbl;
    end else begin
      rec_nxt.dat  = {{(REC_W_D-REC_W_S){1'b0}}, rec_sgl};
      rec_nxt.snan = snan_sgl;
      rec_nxt.sub  = sub_sgl;
    end
  end

  assign s2_adv   = s1_v_q & (~s2_v_q | out_ready);
  assign in_ready = ~flush & (~s1_v_q | s2_adv);
  assign in_acc   = in_valid & in_ready;

  // Stage valids and the saturating subnormal counter; flush kills both stages but not the counter
  always_comb begin
    s1_v_d = s1_v_q;
    s2_v_d = s2_v_q;
    cnt_d  = cnt_q;
    if (in_ready) s1_v_d = in_valid;
    if (s2_adv) begin
      s2_v_d = 1'b1;
    end else if (out_ready) begin
      s2_v_d = 1'b0;
    end
    if (flush) begin
      s1_v_d = 1'b0;
      s2_v_d = 1'b0;
    end
    if (s2_v_q && out_ready && s2_q.sub && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      cnt_q  <= cnt_d;
    end
  end

  // Datapath registers only load on their stage's transfer, so they need no reset
  always_ff @(posedge clk) begin
    if (in_acc) begin
      s1_raw_q <= in_data;
      s1_fmt_q <= fmt_e'(in_fmt);
      s1_tag_q <= in_tag;
    end
    if (s2_adv) begin
      s2_q     <= rec_nxt;
      s2_tag_q <= s1_tag_q;
    end
  end

  assign out_valid   = s2_v_q;
  assign out_data    = s2_q.dat;
  assign out_fmt     = s2_q.fmt;
  assign out_tag     = s2_tag_q;
  assign out_snan    = s2_q.snan;
  assign subnorm_cnt = cnt_q;
  assign occupancy   = {1'b0, s1_v_q} + {1'b0, s2_v_q};

endmodule

// File: doc/fp_load_recode_pipe.md
Name: fp_load_recode_pipe

Overview:
- Two-stage, valid/ready-handshaked pipeline that converts raw IEEE-754 load data (single or double) into the recoded format (exponent one bit wider) before the data is written to the FP register file.
- Sits between the vector load-data return path (upstream) and the FP regfile write port (downstream).
- Carries a destination tag and format through the pipeline.
- Flags signaling NaNs and counts recoded subnormals for performance monitoring.

Parameters:
- TAG_W, 8, width of the destination-register tag carried alongside data.
- CNT_W, 16, width of the saturating subnormal-event counter.

Ports:
- clk  in  1  single clock for all state.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream load data valid.
- in_ready  out  1  block can accept this cycle.
- in_data  in  64  raw load data; single uses [31:0], bits [63:32] ignored.
- in_fmt  in  1  0 = single (E=8, S=24), 1 = double (E=11, S=53).
- in_tag  in  TAG_W  destination tag.
- flush  in  1  synchronous kill of all in-flight entries.
- out_valid  out  1  recoded result valid.
- out_ready  in  1  downstream accepts.
- out_data  out  65  recoded value; single result is zero-extended, {32'b0, rec33}.
- out_fmt  out  1  format of out_data.
- out_tag  out  TAG_W  tag of out_data.
- out_snan  out  1  input was a signaling NaN (exp all ones, fraction nonzero, fraction MSB 0).
- subnorm_cnt  out  CNT_W  saturating count of subnormal inputs that have left stage 2.
- occupancy  out  2  number of valid stages (0..2).

Behaviour:
- Reset (asynchronous, reset_n=0): both stage valids = 0, subnorm_cnt = 0. Hence out_valid = 0, occupancy = 0, in_ready = 1 once reset releases. Data registers are don't-care.
- S1 captures in_data, in_fmt and in_tag on in_valid & in_ready.
- Recoding is combinational between S1 and S2 (fp_recode_unit). S2 holds out_data, out_fmt, out_tag, out_snan and a subnormal bit.
- Latency: 2 cycles from acceptance to out_valid with no backpressure. Throughput is 1 per cycle.
- Advance rules:
  - s2_adv = s1_v & (~s2_v | out_ready).
  - in_ready = ~flush & (~s1_v | s2_adv). This is a combinational path from out_ready to in_ready, and is required.
- out_valid = s2_v. S2 contents are held stable while out_valid & ~out_ready.
- Simultaneous output transfer and s2_adv in one cycle: S2 is replaced, with no bubble.
- flush = 1: next cycle s1_v = s2_v = 0. Any same-cycle input is not accepted (in_ready = 0). An output handshake in the flush cycle still completes. subnorm_cnt is not cleared.
- subnorm_cnt increments by 1 on each out_valid & out_ready whose entry was subnormal. It saturates at 2^CNT_W-1 with no wrap.
- occupancy = s1_v + s2_v.
- Recoding, generic over E (exponent width), fraction F = S-1 bits, bias B = 2^(E-1)+1:
  - Zero: exp_out = 0, fraction 0, sign kept.
  - Normal: exp_out = exp_in + B, computed in E+1 bits. Fraction passes through.
  - Subnormal: lz = leading zeros of the fraction. exp_out = B - lz. fraction_out = fraction << (lz+1), truncated to F bits.
  - Inf: exp_out = (all-ones + B), which has top two bits 11 and bit E-2 clear. Fraction is 0.
  - NaN: Inf exponent with bit E-2 set. Fraction passes through.
- Output layout: {sign, exp_out[E:0], fraction_out[F-1:0]}.

Decomposition:
- Shared package fp_recode_pkg holds:
  - FMT_S / FMT_D encodings.
  - E/S constants per format: 8/24 and 11/53.
  - Bias constants 129 and 1025.
  - Recoded widths 33 and 65.
- Sub-module fp_recode_unit, parameterised by E and S, is purely combinational: leading-zero count, normaliser, exponent adder, class decode (zero, subnormal, sNaN).
  - Instantiated once per format; the result is muxed by the S1 fmt.

Test Plan:
- Reset with reset_n low mid-stream (2 entries in flight) -> out_valid = 0 and occupancy = 0 immediately (asynchronous). After release in_ready = 1 and subnorm_cnt = 0.
- Single 0x3F800000 / 0x00000001 / 0x7F800000 / 0x7FC00000, out_ready held 1 -> out_data 0x080000000 / 0x035800000 / 0x0C0000000 / 0x0E0400000, each exactly 2 cycles after acceptance. subnorm_cnt = 1.
- Double 0x3FF0000000000000 and +0.0 -> out_data 65'h0_8000_0000_0000_0000 and 0. out_fmt = 1 and tags preserved.
- Single 0x7F800001 -> out_snan = 1, out_data 0x0E0000001. Quiet NaN 0x7FC00000 -> out_snan = 0.
- Backpressure: stream 4 entries with out_ready low 3 cycles -> occupancy reaches 2, in_ready = 0, out_data stable. Release -> all 4 emitted in order, no loss or duplication.
- flush while occupancy = 2 and in_valid = 1 -> next cycle occupancy = 0, input not accepted, subnorm_cnt unchanged. Set CNT_W = 2 with 5 subnormals -> counter saturates at 3.
